shift_stream: RTL and testbench
===============================

# shift_stream

Parametrised successor to the team's fixed 8-bit × 32-stage parallel-load shift chain. It takes DEPTH words of WIDTH bits in one parallel load and streams them out one word per accepted beat over a valid/ready handshake. It supports three refill modes (zero-fill, rotate, serial-in), tracks the remaining beat count, and accepts back-to-back loads. It sits between a bank of word sources and a single-word serial consumer.

## Interface
- WIDTH, 8, bits per word (≥1)
- DEPTH, 32, number of stages (≥2)
- CNT_W, $clog2(DEPTH+1), derived localparam; not overridable
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- load  in  1  parallel-load request; acted on only when load_ready=1
- load_data  in  DEPTH*WIDTH  stage i = load_data[i*WIDTH +: WIDTH]
  - stage DEPTH-1 is the output end; stage 0 is the input end
- mode  in  2  refill source, sampled with load
  - 00 zero-fill, 01 rotate, 10 serial-in, 11 reserved (treated as 00)
- ser_in  in  WIDTH  word entering stage 0 on each beat in serial-in mode
- load_ready  out  1  equals !busy || (remaining==1 && out_ready); combinational from out_ready
- out_data  out  WIDTH  current contents of stage DEPTH-1
- out_valid  out  1  a word is offered
- out_ready  in  1  consumer accepts; a beat occurs when out_valid && out_ready
- busy  out  1  high in STREAM state
- remaining  out  CNT_W  beats left in the current stream (DEPTH down to 1); 0 when idle

## Operation
- FSM states: IDLE and STREAM.
  - IDLE → STREAM on load.
  - STREAM → IDLE on a beat with remaining==1, unless load is also accepted in that cycle; then the FSM stays in STREAM.
- Load (load && load_ready):
  - all stages take load_data
  - mode is captured into mode_q
  - remaining := DEPTH
- Beat (STREAM, out_valid && out_ready):
  - stage i+1 := stage i, for i = 0..DEPTH-2
  - stage 0 := 0 (mode_q 00), old stage DEPTH-1 (mode_q 01), or ser_in (mode_q 10)
  - remaining := remaining-1
- Rotate mode: after DEPTH beats the stages hold exactly the loaded image again.
- No beat (out_ready low): stages, out_data and remaining hold.
- Simultaneous last beat and load: the load wins. The new image replaces the shift result and remaining := DEPTH, with no idle bubble.
- load while load_ready=0: ignored, no side effects.
- Stages are not cleared on return to IDLE; out_data shows stage DEPTH-1 but out_valid=0.
- rst during STREAM aborts immediately:
  - all stages 0, IDLE
  - a partial stream is discarded; no further beats are emitted

## Timing
- Reset values: stages 0, out_data 0, out_valid 0, busy 0, remaining 0, mode_q 00, load_ready 1.
- Load at edge N: out_valid=1 and out_data=load_data word DEPTH-1 from cycle N+1, so load-to-first-word latency is 1 cycle.
- Throughput is one word per cycle while out_ready=1. A full stream takes DEPTH cycles minimum.
- out_valid=busy, registered. out_data, out_valid and remaining are register outputs.
- load_ready is the only combinational output.
- ser_in is sampled on the beat edge.

## Structure
- Package shift_pkg holds:
  - mode encodings MODE_ZERO=2'b00, MODE_ROT=2'b01, MODE_SER=2'b10
  - state encodings S_IDLE, S_STREAM
- Sub-module shift_stage (WIDTH parameter) is one word register with ports clk, rst, ld, ld_d, sh, sh_d, q.
  - ld has priority over sh
  - chained DEPTH times with a generate loop
- The top level holds the FSM, the remaining counter, mode_q and the stage-0 refill mux.

## Test plan
- Reset then idle, WIDTH=8, DEPTH=4: all outputs at their reset values; load_ready=1.
- Zero-fill, load words {3:0x44, 2:0x33, 1:0x22, 0:0x11}, out_ready=1:
  - out_data 0x44, 0x33, 0x22, 0x11 on cycles N+1..N+4
  - remaining 4, 3, 2, 1; then out_valid=0, stages all 0
- Rotate, same data, out_ready toggled 1,0,1,0,…:
  - data holds while ready=0
  - 4 beats emit 0x44..0x11, then the stages equal the loaded image
- Serial-in, ser_in=0xA0+beat index: after 4 beats stages {3:0xA0, 2:0xA1, 1:0xA2, 0:0xA3}.
- Back-to-back: at the last beat of stream 1, load 0x55-filled with out_ready=1:
  - next cycle out_valid=1, out_data=0x55, remaining=4, no bubble
- Abort and ignore:
  - rst asserted at remaining=2: next cycle all outputs at reset values
  - load with out_ready=0 mid-stream is ignored; remaining unchanged

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift_stream block: refill modes and FSM states.
// Also holds the mode decoder so the reserved encoding is handled in one place.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'b00,
        MODE_ROT  = 2'b01,
        MODE_SER  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    // Reserved encoding folds onto zero-fill so mode_q never holds MODE_RSVD.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_ROT;
            2'b10:   return MODE_SER;
            default: return MODE_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One word register of the shift chain; a parallel load beats a shift.
module shift_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_d,
    input  logic             sh,
    input  logic [WIDTH-1:0] sh_d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_d;
        end else if (sh) begin
            q <= sh_d;
        end
    end

endmodule

// File: rtl/shift_stream.sv
// Parallel-load, word-serial output shift chain with valid/ready handshake,
// selectable stage-0 refill, remaining-beat counter and back-to-back loads.
module shift_stream
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] load_data,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       ser_in,
    output logic                   load_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       remaining
);

    state_e           state_q;
    state_e           state_d;
    mode_e            mode_q;
    logic [CNT_W-1:0] remaining_q;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] refill;
    logic             beat;
    logic             last_beat;
    logic             load_fire;

    assign busy       = (state_q == S_STREAM);
    assign beat       = busy && out_ready;
    assign last_beat  = beat && (remaining_q == CNT_W'(1));
    // A load may land on the final beat so consecutive streams have no gap.
    assign load_ready = !busy || ((remaining_q == CNT_W'(1)) && out_ready);
    assign load_fire  = load && load_ready;

    assign out_valid  = busy;
    assign out_data   = stage_q[DEPTH-1];
    assign remaining  = remaining_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: default first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_fire) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_beat && !load_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            mode_q      <= MODE_ZERO;
        end else if (load_fire) begin
            remaining_q <= CNT_W'(DEPTH);
            mode_q      <= decode_mode(mode);
        end else if (beat) begin
            remaining_q <= remaining_q - CNT_W'(1);
        end
    end

    always_comb begin
        refill = '0;
        case (mode_q)
            MODE_ROT: refill = stage_q[DEPTH-1];
            MODE_SER: refill = ser_in;
            default:  refill = '0;
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] sh_d;

        if (i == 0) begin : g_head
            assign sh_d = refill;
        end else begin : g_body
            assign sh_d = stage_q[i-1];
        end

        shift_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .ld   (load_fire),
            .ld_d (load_data[i*WIDTH +: WIDTH]),
            .sh   (beat),
            .sh_d (sh_d),
            .q    (stage_q[i])
        );
    end

endmodule

// File: tb/tb_shift_stream.sv
// Directed bench for shift_stream at WIDTH=8, DEPTH=4: reset, each refill
// mode, back-to-back load, ignored load and mid-stream abort.
module tb_shift_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam logic [31:0] IMG = 32'h44332211;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   load;
    logic [DEPTH*WIDTH-1:0] load_data;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       ser_in;
    logic                   load_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic [CNT_W-1:0]       remaining;

    int passed = 0;
    int total  = 0;

    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    shift_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .mode       (mode),
        .ser_in     (ser_in),
        .load_ready (load_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stages();
        return {dut.stage_q[3], dut.stage_q[2], dut.stage_q[1], dut.stage_q[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_img(input logic [31:0] img, input logic [1:0] m, input logic rdy);
        load      = 1'b1;
        load_data = img;
        mode      = m;
        out_ready = rdy;
        tick();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; load_data = '0; mode = 2'b00; ser_in = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (remaining !== 3'd0) $display("FAIL reset_remaining: got %0d want 0", remaining); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b want 1", load_ready); else passed++;
        total++; if (stages() !== 32'h0) $display("FAIL reset_stages: got %h want 00000000", stages()); else passed++;
    endtask

    task automatic test_zero_fill();
        load_img(IMG, 2'b00, 1'b1);
        for (int b = 0; b < 4; b++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL zero_valid[%0d]: got %b want 1", b, out_valid); else passed++;
            total++; if (out_data !== w[3-b]) $display("FAIL zero_data[%0d]: got %h want %h", b, out_data, w[3-b]); else passed++;
            total++; if (remaining !== 3'(4 - b)) $display("FAIL zero_rem[%0d]: got %0d want %0d", b, remaining, 4 - b); else passed++;
            tick();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL zero_end_valid: got %b want 0", out_valid); else passed++;
        total++; if (remaining !== 3'd0) $display("FAIL zero_end_rem: got %0d want 0", remaining); else passed++;
        total++; if (stages() !== 32'h0) $display("FAIL zero_end_stages: got %h want 00000000", stages()); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL zero_end_load_ready: got %b want 1", load_ready); else passed++;
    endtask

    task automatic test_rotate();
        int beats;
        beats = 0;
        load_img(IMG, 2'b01, 1'b0);
        for (int k = 0; k < 8; k++) begin
            out_ready = (k % 2 == 0);
            tick();
            if (out_ready && beats < 4) beats++;
            if (beats < 4) begin
                total++; if (out_data !== w[3-beats]) $display("FAIL rot_data[%0d]: got %h want %h", k, out_data, w[3-beats]); else passed++;
                total++; if (remaining !== 3'(4 - beats)) $display("FAIL rot_rem[%0d]: got %0d want %0d", k, remaining, 4 - beats); else passed++;
            end else begin
                total++; if (out_valid !== 1'b0) $display("FAIL rot_idle_valid[%0d]: got %b want 0", k, out_valid); else passed++;
            end
        end
        total++; if (stages() !== IMG) $display("FAIL rot_image: got %h want %h", stages(), IMG); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_serial();
        load_img(IMG, 2'b10, 1'b1);
        for (int b = 0; b < 4; b++) begin
            ser_in = 8'(8'hA0 + b);
            tick();
            if (b < 3) begin
                total++; if (out_data !== w[2-b]) $display("FAIL ser_data[%0d]: got %h want %h", b, out_data, w[2-b]); else passed++;
            end
        end
        total++; if (out_valid !== 1'b0) $display("FAIL ser_end_valid: got %b want 0", out_valid); else passed++;
        total++; if (stages() !== 32'hA0A1A2A3) $display("FAIL ser_stages: got %h want a0a1a2a3", stages()); else passed++;
        total++; if (out_data !== 8'hA0) $display("FAIL ser_idle_data: got %h want a0", out_data); else passed++;
    endtask

    task automatic test_reserved();
        ser_in = 8'hFF;
        load_img(IMG, 2'b11, 1'b1);
        repeat (4) tick();
        total++; if (stages() !== 32'h0) $display("FAIL rsvd_stages: got %h want 00000000", stages()); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rsvd_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        load_img(IMG, 2'b00, 1'b1);
        repeat (3) tick();
        total++; if (remaining !== 3'd1) $display("FAIL b2b_rem1: got %0d want 1", remaining); else passed++;
        out_ready = 1'b0;
        #1;
        total++; if (load_ready !== 1'b0) $display("FAIL b2b_ready_low: got %b want 0", load_ready); else passed++;
        out_ready = 1'b1;
        #1;
        total++; if (load_ready !== 1'b1) $display("FAIL b2b_ready_high: got %b want 1", load_ready); else passed++;
        load_img(32'h55555555, 2'b00, 1'b1);
        total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_data !== 8'h55) $display("FAIL b2b_data: got %h want 55", out_data); else passed++;
        total++; if (remaining !== 3'd4) $display("FAIL b2b_rem: got %0d want 4", remaining); else passed++;
        tick();
        total++; if (remaining !== 3'd3) $display("FAIL b2b_rem3: got %0d want 3", remaining); else passed++;
        total++; if (out_data !== 8'h55) $display("FAIL b2b_data2: got %h want 55", out_data); else passed++;
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_end_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_ignore();
        load_img(IMG, 2'b01, 1'b0);
        load      = 1'b1;
        load_data = 32'h99999999;
        mode      = 2'b10;
        ser_in    = 8'hEE;
        #1;
        total++; if (load_ready !== 1'b0) $display("FAIL ign_load_ready: got %b want 0", load_ready); else passed++;
        tick();
        load = 1'b0;
        total++; if (remaining !== 3'd4) $display("FAIL ign_rem: got %0d want 4", remaining); else passed++;
        total++; if (out_data !== 8'h44) $display("FAIL ign_data: got %h want 44", out_data); else passed++;
        out_ready = 1'b1;
        repeat (4) tick();
        total++; if (stages() !== IMG) $display("FAIL ign_mode_kept: got %h want %h", stages(), IMG); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL ign_end_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_abort();
        load_img(IMG, 2'b00, 1'b1);
        tick();
        tick();
        total++; if (remaining !== 3'd2) $display("FAIL abort_rem2: got %0d want 2", remaining); else passed++;
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        total++; if (remaining !== 3'd0) $display("FAIL abort_rem: got %0d want 0", remaining); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL abort_data: got %h want 00", out_data); else passed++;
        total++; if (stages() !== 32'h0) $display("FAIL abort_stages: got %h want 00000000", stages()); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL abort_load_ready: got %b want 1", load_ready); else passed++;
        rst = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL abort_no_beat: got %b want 0", out_valid); else passed++;
        total++; if (remaining !== 3'd0) $display("FAIL abort_rem_after: got %0d want 0", remaining); else passed++;
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_rotate();
        test_serial();
        test_reserved();
        test_back_to_back();
        test_ignore();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
